bpc_cxd_fifo: RTL and testbench

- Buffers arranged CX/D bytes from the arrange stage and hands them to the MQ coder.
- Back-pressures the arrange stage through stall_vld before the buffer can overflow.
- Write side is qualified by the pos_clk_bpc enable. Read side is a show-ahead valid/ready handshake driven by the MQ coder.
- Everything runs on clk_dwt, with rst and rst_syn semantics identical to the rest of the bpc_mq path.

---
 rtl/bpc_mq_pkg.sv | 22 ++
 rtl/bpc_cxd_fifo_if.sv | 27 ++
 rtl/bpc_cxd_ram.sv | 26 ++
 rtl/bpc_cxd_fifo.sv | 95 +++++++++
 tb/tb_bpc_cxd_fifo.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/bpc_mq_pkg.sv
// Shared constants for the bpc_mq path: CX/D entry layout and CX/D FIFO defaults.
package bpc_mq_pkg;

    localparam int CXD_W             = 8;
    localparam int CX_MSB            = 7;
    localparam int CX_LSB            = 3;
    localparam int D_BIT             = 2;

    localparam int FIFO_DEPTH        = 16;
    localparam int FIFO_AW           = 4;
    localparam int FIFO_STALL_MARGIN = 3;

    // Builds an entry the same way the arrange stage does; the two low bits are spare.
    function automatic logic [CXD_W-1:0] cxd_pack(input logic [4:0] cx, input logic d);
        logic [CXD_W-1:0] r;
        r                = '0;
        r[CX_MSB:CX_LSB] = cx;
        r[D_BIT]         = d;
        return r;
    endfunction

endpackage

// File: rtl/bpc_cxd_fifo_if.sv
// Handshake bundle between the arrange stage, the CX/D FIFO and the MQ coder.
interface bpc_cxd_fifo_if
    import bpc_mq_pkg::*;
#(
    parameter int DW = CXD_W,
    parameter int AW = FIFO_AW
);
    logic          pos_clk_bpc;
    logic [DW-1:0] cxd_in;
    logic          cxd_in_vld;
    logic          stall_vld;
    logic [DW-1:0] cxd_out;
    logic          cxd_out_vld;
    logic          mq_rdy;
    logic [AW:0]   fifo_cnt;
    logic          ovf_err;

    modport slave (
        input  pos_clk_bpc, cxd_in, cxd_in_vld, mq_rdy,
        output stall_vld, cxd_out, cxd_out_vld, fifo_cnt, ovf_err
    );

    modport master (
        output pos_clk_bpc, cxd_in, cxd_in_vld, mq_rdy,
        input  stall_vld, cxd_out, cxd_out_vld, fifo_cnt, ovf_err
    );
endinterface

// File: rtl/bpc_cxd_ram.sv
// Storage for the CX/D FIFO: synchronous write, asynchronous read, no reset.
module bpc_cxd_ram
    import bpc_mq_pkg::*;
#(
    parameter int DW    = CXD_W,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW
) (
    input  logic          clk_dwt,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk_dwt) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bpc_cxd_fifo.sv
// CX/D FIFO between the arrange stage and the MQ coder: show-ahead read side,
// pos_clk_bpc-qualified write side and registered back-pressure.
module bpc_cxd_fifo
    import bpc_mq_pkg::*;
#(
    parameter int DW           = CXD_W,
    parameter int DEPTH        = FIFO_DEPTH,
    parameter int AW           = FIFO_AW,
    parameter int STALL_MARGIN = FIFO_STALL_MARGIN
) (
    input  logic          clk_dwt,
    input  logic          rst,
    input  logic          rst_syn,
    bpc_cxd_fifo_if.slave bus
);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] MARGIN_C = (AW+1)'(STALL_MARGIN);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   next_count;
    logic [AW:0]   free_next;
    logic          wr;
    logic          rd;
    logic          wr_acc;
    logic          wr_drop;
    logic          ram_we;
    logic          ovf_q;
    logic [DW-1:0] ram_rdata;

    // The arrange stage keeps vld high while stalled, so stall must gate the write itself.
    always_comb begin
        wr         = bus.pos_clk_bpc & bus.cxd_in_vld & ~bus.stall_vld;
        rd         = bus.mq_rdy & (count != '0);
        wr_acc     = wr & ((count != DEPTH_C) | rd);
        wr_drop    = wr & ~wr_acc;
        ram_we     = wr_acc & ~rst_syn & rst;
        next_count = count;
        if (wr_acc && !rd) begin
            next_count = count + 1'b1;
        end else if (rd && !wr_acc) begin
            next_count = count - 1'b1;
        end
        free_next  = DEPTH_C - next_count;
    end

    bpc_cxd_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_dwt (clk_dwt),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr),
        .wr_data (bus.cxd_in),
        .rd_addr (rd_ptr),
        .rd_data (ram_rdata)
    );

    // Stall looks at next_count so it lands on the same edge the threshold is crossed.
    always_ff @(posedge clk_dwt or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.stall_vld <= 1'b0;
            ovf_q         <= 1'b0;
        end else if (rst_syn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.stall_vld <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count         <= next_count;
            bus.stall_vld <= (free_next <= MARGIN_C);
            if (wr_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.cxd_out_vld = (count != '0);
    assign bus.cxd_out     = bus.cxd_out_vld ? ram_rdata : '0;
    assign bus.fifo_cnt    = count;
    assign bus.ovf_err     = ovf_q;

endmodule

// File: tb/tb_bpc_cxd_fifo.sv
// Randomised and directed bench for bpc_cxd_fifo with a queue-based reference model
// and a scoreboard monitor that checks the head whenever the FIFO presents data.
module tb_bpc_cxd_fifo;
    import bpc_mq_pkg::*;

    localparam int DEPTH  = 16;
    localparam int MARGIN = 3;

    logic clk_dwt = 1'b0;
    logic rst     = 1'b0;
    logic rst_syn = 1'b0;

    bpc_cxd_fifo_if #(.DW(8), .AW(4)) bus ();

    bpc_cxd_fifo #(
        .DW           (8),
        .DEPTH        (DEPTH),
        .AW           (4),
        .STALL_MARGIN (MARGIN)
    ) dut (
        .clk_dwt (clk_dwt),
        .rst     (rst),
        .rst_syn (rst_syn),
        .bus     (bus)
    );

    always #5 clk_dwt = ~clk_dwt;

    logic [7:0] exp_q[$];
    int         m_cnt   = 0;
    bit         m_stall = 1'b0;
    bit         m_ovf   = 1'b0;
    bit         ovr     = 1'b0;
    int         n_cmp   = 0;
    int         n_bad   = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue occupancy rules evaluated at each clock edge.
    always @(posedge clk_dwt or negedge rst) begin
        if (!rst) begin
            exp_q.delete();
            m_cnt   = 0;
            m_stall = 1'b0;
            m_ovf   = 1'b0;
        end else if (rst_syn) begin
            exp_q.delete();
            m_cnt   = 0;
            m_stall = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            bit w, r, acc;
            w   = bus.pos_clk_bpc && bus.cxd_in_vld && !(ovr ? 1'b0 : m_stall);
            r   = bus.mq_rdy && (m_cnt > 0);
            acc = w && ((m_cnt < DEPTH) || r);
            if (acc) exp_q.push_back(bus.cxd_in);
            if (w && !acc) m_ovf = 1'b1;
            m_cnt   = m_cnt + int'(acc) - int'(r);
            m_stall = (DEPTH - m_cnt) <= MARGIN;
        end
    end

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk_dwt) begin
        check_output("fifo_cnt", bus.fifo_cnt, m_cnt);
        check_output("cxd_out_vld", bus.cxd_out_vld, m_cnt != 0);
        check_output("ovf_err", bus.ovf_err, m_ovf);
        if (!ovr) check_output("stall_vld", bus.stall_vld, m_stall);
        if (bus.cxd_out_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("[TB] FAIL head_empty: got 'h%0h with valid, expected nothing queued", bus.cxd_out);
            end else begin
                check_output("head", bus.cxd_out, exp_q[0]);
                if (bus.mq_rdy && !rst_syn && rst) void'(exp_q.pop_front());
            end
        end else begin
            check_output("cxd_out_zero", bus.cxd_out, 0);
        end
    end

    task automatic apply_stimulus(input bit pos, input bit vld, input logic [7:0] din, input bit rdy);
        bus.pos_clk_bpc = pos;
        bus.cxd_in_vld  = vld;
        bus.cxd_in      = din;
        bus.mq_rdy      = rdy;
        @(posedge clk_dwt);
        #2;
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int sent, guard;
        bus.pos_clk_bpc = 1'b0;
        bus.cxd_in_vld  = 1'b0;
        bus.cxd_in      = '0;
        bus.mq_rdy      = 1'b0;
        repeat (2) @(posedge clk_dwt);
        #2;
        rst = 1'b1;
        repeat (3) apply_stimulus(0, 0, 8'h00, 0);
        check_output("reset_cnt", bus.fifo_cnt, 0);
        check_output("reset_out", bus.cxd_out, 0);

        // rst_syn wins over a same-cycle write
        rst_syn = 1'b1;
        apply_stimulus(1, 1, 8'h77, 1);
        rst_syn = 1'b0;
        apply_stimulus(0, 0, 8'h00, 0);
        check_output("syn_cnt", bus.fifo_cnt, 0);
        check_output("syn_stall", bus.stall_vld, 0);

        // BPC enable every other cycle, data held valid in between
        apply_stimulus(1, 1, 8'hA1, 0);
        apply_stimulus(0, 1, 8'hEE, 0);
        apply_stimulus(1, 1, 8'hB2, 0);
        apply_stimulus(0, 1, 8'hEE, 0);
        apply_stimulus(1, 1, 8'hC3, 0);
        apply_stimulus(0, 0, 8'h00, 0);
        check_output("three_cnt", bus.fifo_cnt, 3);
        check_output("three_head", bus.cxd_out, 8'hA1);
        repeat (3) apply_stimulus(0, 0, 8'h00, 1);
        apply_stimulus(0, 0, 8'h00, 0);
        check_output("drained_vld", bus.cxd_out_vld, 0);

        // Fill until stall gates further writes
        for (int i = 0; i < 20; i++) apply_stimulus(1, 1, 8'(8'h10 + i), 0);
        check_output("fill_cnt", bus.fifo_cnt, 13);
        check_output("fill_stall", bus.stall_vld, 1);
        check_output("fill_ovf", bus.ovf_err, 0);

        // Override stall to reach full and provoke overflow
        ovr = 1'b1;
        force bus.stall_vld = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus(1, 1, 8'(8'h40 + i), 0);
        check_output("full_cnt", bus.fifo_cnt, 16);
        apply_stimulus(1, 1, 8'h43, 1);
        check_output("full_rw_cnt", bus.fifo_cnt, 16);
        check_output("full_rw_head", bus.cxd_out, 8'h11);
        apply_stimulus(1, 1, 8'h44, 0);
        check_output("ovf_set", bus.ovf_err, 1);
        release bus.stall_vld;
        apply_stimulus(0, 0, 8'h00, 0);
        ovr = 1'b0;
        repeat (2) apply_stimulus(0, 0, 8'h00, 0);
        check_output("ovf_sticky", bus.ovf_err, 1);
        rst_syn = 1'b1;
        apply_stimulus(0, 0, 8'h00, 0);
        rst_syn = 1'b0;
        check_output("ovf_cleared", bus.ovf_err, 0);
        check_output("syn2_cnt", bus.fifo_cnt, 0);

        // Pointer wrap with random enable and consumer readiness
        sent  = 0;
        guard = 0;
        while (sent < 40 && guard < 1000) begin
            bit p, r, take;
            p    = 1'($urandom_range(0, 1));
            r    = 1'($urandom_range(0, 1));
            take = p && (bus.stall_vld === 1'b0);
            apply_stimulus(p, 1, 8'(sent), r);
            if (take) sent++;
            guard++;
        end
        check_output("wrap_sent", sent, 40);
        guard = 0;
        while (m_cnt > 0 && guard < 60) begin
            apply_stimulus(0, 0, 8'h00, 1);
            guard++;
        end
        apply_stimulus(0, 0, 8'h00, 0);
        check_output("wrap_left", exp_q.size(), 0);
        check_output("wrap_cnt", bus.fifo_cnt, 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) apply_stimulus(1, 1, 8'(8'h60 + i), 0);
        bus.cxd_in_vld = 1'b0;
        rst = 1'b0;
        #1;
        check_output("arst_cnt", bus.fifo_cnt, 0);
        check_output("arst_vld", bus.cxd_out_vld, 0);
        check_output("arst_out", bus.cxd_out, 0);
        check_output("arst_stall", bus.stall_vld, 0);
        @(posedge clk_dwt);
        #2;
        rst = 1'b1;
        apply_stimulus(1, 1, 8'h5A, 0);
        apply_stimulus(0, 0, 8'h00, 0);
        check_output("post_arst_head", bus.cxd_out, 8'h5A);
        check_output("post_arst_cnt", bus.fifo_cnt, 1);
        apply_stimulus(0, 0, 8'h00, 1);
        repeat (2) apply_stimulus(0, 0, 8'h00, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
